// File: rtl/adc_serial_capture.sv
// rtl/adc_serial_capture.sv - shared-clock multi-channel serial ADC capture with aligned parallel output
// Optional per-channel frame averaging is built when ADC_AVG_EN is defined.
module adc_serial_capture #(
   parameter int NCH        = 2,
   parameter int DATA_W     = 12,
   parameter int FRAME_BITS = 16,
   parameter int QUIET_CYC  = 2,
   parameter int AVG_LOG2   = 2
) (
   input  logic                  clk_3M,
   input  logic                  reset,
   input  logic                  sensor_clk,
   input  logic                  sample_control,
   input  logic [NCH-1:0]        Data,
   output logic                  ADC_clk,
   output logic                  chip_select,
   output logic [NCH*DATA_W-1:0] pdata,
   output logic                  pdata_valid,
   output logic                  busy,
   output logic                  overrun
);

   localparam int BC_W = $clog2(FRAME_BITS + 1);
   localparam int QC_W = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;

   generate
      if (FRAME_BITS < DATA_W || QUIET_CYC < 1 || AVG_LOG2 < 0 || DATA_W < 2) begin : g_bad_cfg
         $error("adc_serial_capture: invalid parameter combination");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, CONV, QUIET} state_t;

   state_t            state, state_nx;
   logic              sensor_q;
   logic              trigger;
   logic              start;
   logic              lead;
   logic              frame_done;
   logic              quiet_last;
   logic [BC_W-1:0]   bit_cnt;
   logic [QC_W-1:0]   quiet_cnt;
   logic [DATA_W-1:0] shift_reg [NCH];

`ifdef ADC_AVG_EN
   localparam int ACC_W = DATA_W + AVG_LOG2;
   localparam int FC_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

   logic [ACC_W-1:0]  acc     [NCH];
   logic [ACC_W-1:0]  acc_sum [NCH];
   logic [FC_W-1:0]   frame_cnt;
   logic              avg_last;

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         acc_sum[i] = acc[i] + ACC_W'(shift_reg[i]);
      end
   end

   assign avg_last = (frame_cnt == FC_W'((1 << AVG_LOG2) - 1));
`endif

   assign trigger    = sensor_clk & ~sensor_q;
   assign frame_done = (state == CONV) && !lead && ADC_clk && (bit_cnt == BC_W'(FRAME_BITS));
   assign quiet_last = (state == QUIET) && (quiet_cnt == QC_W'(QUIET_CYC - 1));
   // The final quiet cycle may launch the next frame directly, so it is not an overrun window.
   assign start      = trigger && sample_control && ((state == IDLE) || quiet_last);
   assign busy       = (state != IDLE);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = CONV;
         CONV:    if (frame_done) state_nx = QUIET;
         QUIET:   if (quiet_last) state_nx = start ? CONV : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_3M or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_ff @(posedge clk_3M or posedge reset) begin
      if (reset) begin
         sensor_q    <= 1'b0;
         chip_select <= 1'b1;
         ADC_clk     <= 1'b1;
         pdata       <= '0;
         pdata_valid <= 1'b0;
         overrun     <= 1'b0;
         lead        <= 1'b0;
         bit_cnt     <= '0;
         quiet_cnt   <= '0;
         for (int i = 0; i < NCH; i++) shift_reg[i] <= '0;
`ifdef ADC_AVG_EN
         frame_cnt   <= '0;
         for (int i = 0; i < NCH; i++) acc[i] <= '0;
`endif
      end else begin
         sensor_q    <= sensor_clk;
         pdata_valid <= 1'b0;
         if (trigger && busy && !quiet_last) overrun <= 1'b1;

         if (start) begin
            chip_select <= 1'b0;
            ADC_clk     <= 1'b0;
            bit_cnt     <= '0;
            lead        <= 1'b1;
         end else if (state == CONV) begin
            // ADC_clk stays low one extra cycle after select so the first rise lands at T+2.
            if (lead) begin
               lead <= 1'b0;
            end else if (!ADC_clk) begin
               ADC_clk <= 1'b1;
               bit_cnt <= bit_cnt + 1'b1;
               for (int i = 0; i < NCH; i++) begin
                  shift_reg[i] <= {shift_reg[i][DATA_W-2:0], Data[i]};
               end
            end else if (frame_done) begin
               chip_select <= 1'b1;
               quiet_cnt   <= '0;
`ifdef ADC_AVG_EN
               frame_cnt   <= avg_last ? '0 : frame_cnt + 1'b1;
               if (avg_last) begin
                  pdata_valid <= 1'b1;
                  for (int i = 0; i < NCH; i++) begin
                     pdata[i*DATA_W +: DATA_W] <= acc_sum[i][AVG_LOG2 +: DATA_W];
                     acc[i]                    <= '0;
                  end
               end else begin
                  for (int i = 0; i < NCH; i++) acc[i] <= acc_sum[i];
               end
`else
               pdata_valid <= 1'b1;
               for (int i = 0; i < NCH; i++) begin
                  pdata[i*DATA_W +: DATA_W] <= shift_reg[i];
               end
`endif
            end else begin
               ADC_clk <= 1'b0;
            end
         end else if (state == QUIET) begin
            quiet_cnt <= quiet_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_adc_serial_capture.sv
// tb/tb_adc_serial_capture.sv - scoreboard bench for adc_serial_capture
// Expected words are queued at trigger time; a monitor pops them on every pdata_valid.
module tb_adc_serial_capture;

   localparam int NCH = 2;
   localparam int DW  = 12;
   localparam int FB  = 16;

   logic                clk_3M = 1'b0;
   logic                reset = 1'b1;
   logic                sensor_clk = 1'b0;
   logic                sample_control = 1'b0;
   logic [NCH-1:0]      Data;
   logic                ADC_clk;
   logic                chip_select;
   logic [NCH*DW-1:0]   pdata;
   logic                pdata_valid;
   logic                busy;
   logic                overrun;

   adc_serial_capture dut (
      .clk_3M         (clk_3M),
      .reset          (reset),
      .sensor_clk     (sensor_clk),
      .sample_control (sample_control),
      .Data           (Data),
      .ADC_clk        (ADC_clk),
      .chip_select    (chip_select),
      .pdata          (pdata),
      .pdata_valid    (pdata_valid),
      .busy           (busy),
      .overrun        (overrun)
   );

   always #5 clk_3M = ~clk_3M;

   int cyc = 0;
   always @(posedge clk_3M) cyc++;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [NCH*DW-1:0] data;
      int                at;
   } exp_t;
   exp_t sb[$];

   // ADC model: word bits presented MSB first, advancing after each ADC_clk rise.
   logic [FB-1:0] word [NCH];
   int k = 0;
   always @(negedge chip_select) k = 0;
   always @(posedge ADC_clk) if (!chip_select) k++;
   always @* begin
      for (int i = 0; i < NCH; i++) Data[i] = (k < FB) ? word[i][FB-1-k] : 1'b0;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk_3M) begin
      if (pdata_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_valid", 64'(pdata), 64'hDEAD);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("pdata", 64'(pdata), 64'(e.data));
            chk("latency_cycle", 64'(cyc), 64'(e.at));
            chk("adc_clk_pulses", 64'(k), 64'(FB));
         end
      end
   end

   task automatic trig(output int t);
      @(negedge clk_3M);
      sensor_clk = 1'b1;
      t = cyc + 1;
      @(negedge clk_3M);
      sensor_clk = 1'b0;
   endtask

   task automatic frame(input logic [FB-1:0] w0, input logic [FB-1:0] w1,
                        input logic [NCH*DW-1:0] exp, input bit expect_out, output int t);
      word[0] = w0;
      word[1] = w1;
      trig(t);
      if (expect_out) sb.push_back('{exp, t + 2*FB + 1});
      chk("cs_low_at_trigger", 64'(chip_select), 64'd0);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 200) begin
         @(negedge clk_3M);
         n++;
      end
      chk("idle_timeout", 64'(busy), 64'd0);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk_3M);
         n++;
      end
      chk("drain_timeout", 64'(sb.size()), 64'd0);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_cs"},      64'(chip_select), 64'd1);
      chk({tag, "_adc_clk"}, 64'(ADC_clk),     64'd1);
      chk({tag, "_pdata"},   64'(pdata),       64'd0);
      chk({tag, "_valid"},   64'(pdata_valid), 64'd0);
      chk({tag, "_busy"},    64'(busy),        64'd0);
      chk({tag, "_overrun"}, 64'(overrun),     64'd0);
   endtask

   initial begin
      int t, t2, tx, lows;
      word[0] = '0;
      word[1] = '0;
      repeat (3) @(negedge clk_3M);
      check_reset_state("reset");
      reset = 1'b0;
      sample_control = 1'b1;
      repeat (2) @(negedge clk_3M);

`ifdef ADC_AVG_EN
      frame(16'h0100, 16'h07FF, '0, 1'b0, t);
      wait_idle();
      frame(16'h0101, 16'h0800, '0, 1'b0, t);
      wait_idle();
      frame(16'h0102, 16'h0001, '0, 1'b0, t);
      wait_idle();
      frame(16'h0103, 16'h0002, {12'h400, 12'h101}, 1'b1, t);
      wait_drain();
      wait_idle();
      for (int f = 0; f < 4; f++) begin
         frame(16'h0FFF, 16'hF000, {12'h000, 12'hFFF}, f == 3, t);
         wait_idle();
      end
      wait_drain();
`else
      frame(16'h0AAA, 16'h0555, {12'h555, 12'hAAA}, 1'b1, t);
      chk("adc_clk_low_T",  64'(ADC_clk), 64'd0);
      chk("busy_at_T",      64'(busy),    64'd1);
      @(negedge clk_3M);
      chk("adc_clk_low_T1", 64'(ADC_clk), 64'd0);
      @(negedge clk_3M);
      chk("adc_clk_high_T2", 64'(ADC_clk), 64'd1);
      @(negedge clk_3M);
      chk("adc_clk_low_T3", 64'(ADC_clk), 64'd0);

      // Earliest accepted retrigger: sensor edge lands at T+35.
      while (cyc < t + 2*FB + 1) @(negedge clk_3M);
      frame(16'hF123, 16'hA80F, {12'h80F, 12'h123}, 1'b1, t2);
      chk("b2b_busy", 64'(busy), 64'd1);
      wait_drain();
      chk("b2b_no_overrun", 64'(overrun), 64'd0);
      wait_idle();
      repeat (5) @(negedge clk_3M);
      chk("pdata_hold", 64'(pdata), 64'h80F123);

      sample_control = 1'b0;
      trig(tx);
      lows = 0;
      repeat (40) begin
         @(negedge clk_3M);
         if (!chip_select || busy) lows++;
      end
      chk("disabled_no_frame", 64'(lows), 64'd0);
      sample_control = 1'b1;

      frame(16'h0FFF, 16'h0000, {12'h000, 12'hFFF}, 1'b1, t);
      repeat (9) @(negedge clk_3M);
      trig(tx);
      @(negedge clk_3M);
      chk("overrun_set", 64'(overrun), 64'd1);
      wait_drain();
      chk("overrun_sticky_1", 64'(overrun), 64'd1);
      wait_idle();
      frame(16'h0001, 16'h0800, {12'h800, 12'h001}, 1'b1, t);
      wait_drain();
      chk("overrun_sticky_2", 64'(overrun), 64'd1);
      wait_idle();

      frame(16'h0321, 16'h0654, '0, 1'b0, t);
      for (int n = 0; n < 100 && k < 7; n++) @(negedge clk_3M);
      chk("bit7_reached", 64'(k >= 7), 64'd1);
      reset = 1'b1;
      #1;
      check_reset_state("midframe_reset");
      @(negedge clk_3M);
      reset = 1'b0;
      repeat (2) @(negedge clk_3M);
      frame(16'h0123, 16'h0ABC, {12'hABC, 12'h123}, 1'b1, t);
      wait_drain();
      wait_idle();
`endif

      repeat (40) @(negedge clk_3M);
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
